// File: rtl/sid_pkg.sv
// Shared SID definitions: volume width, default voice geometry and a constant-foldable clog2.
package sid_pkg;

    localparam int SID_VOL_W      = 4;
    localparam int SID_VOICE_W    = 8;
    localparam int SID_NUM_VOICES = 3;

    // Ceiling log2 usable in parameter expressions; clog2(1) is 0.
    function automatic int sid_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sid_audio_mod.sv
// Single-bit audio modulator: PWM comparator by default, first-order delta-sigma
// when SID_AUDIO_DELTA_SIGMA_EN is defined.
module sid_audio_mod
#(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] cnt,
    input  logic [PWM_W-1:0] level,
    output logic             audio_out
);

`ifdef SID_AUDIO_DELTA_SIGMA_EN
    logic [PWM_W:0] ds_acc_q;
    logic [PWM_W:0] ds_acc_d;
    logic           unused_cnt;

    assign unused_cnt = ^cnt;
    assign ds_acc_d   = {1'b0, ds_acc_q[PWM_W-1:0]} + {1'b0, level};

    // The stored carry bit doubles as the registered output bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ds_acc_q <= '0;
        end else begin
            ds_acc_q <= ds_acc_d;
        end
    end

    assign audio_out = ds_acc_q[PWM_W];
`else
    logic audio_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            audio_q <= 1'b0;
        end else begin
            audio_q <= (cnt < level);
        end
    end

    assign audio_out = audio_q;
`endif

endmodule

// File: rtl/sid_audio_out.sv
// SID audio output stage: per-frame mix of unmuted voices, master volume scaling and the
// 1-bit pin modulator (delta-sigma instead of PWM when SID_AUDIO_DELTA_SIGMA_EN is defined).
module sid_audio_out
    import sid_pkg::*;
#(
    parameter int NUM_VOICES = SID_NUM_VOICES,
    parameter int VOICE_W    = SID_VOICE_W,
    parameter int PWM_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_VOICES*VOICE_W-1:0] voices,
    input  logic [NUM_VOICES-1:0]         voice_mute,
    input  logic [SID_VOL_W-1:0]          volume,
    output logic [PWM_W-1:0]              level,
    output logic                          frame_start,
    output logic                          audio_out
);

    localparam int SUM_W = VOICE_W + sid_clog2(NUM_VOICES);
    localparam int MIX_W = SUM_W + SID_VOL_W;

    localparam logic [PWM_W-1:0] CNT_MAX    = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] SUM_AT     = CNT_MAX - PWM_W'(2);
    localparam logic [PWM_W-1:0] LEVEL_AT   = CNT_MAX - PWM_W'(1);

    logic [PWM_W-1:0] cnt_q;
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;
    logic [MIX_W-1:0] mix;
    logic [PWM_W-1:0] level_next_q;
    logic [PWM_W-1:0] level_next_d;
    logic [PWM_W-1:0] level_q;
    logic             frame_start_q;

    // Sum of unmuted voices; the extra clog2 bits make overflow impossible.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!voice_mute[i]) begin
                sum_d = sum_d + SUM_W'(voices[i*VOICE_W +: VOICE_W]);
            end
        end
    end

    assign mix = MIX_W'(sum_q) * MIX_W'(volume);

    generate
        if (MIX_W >= PWM_W) begin : g_trunc
            logic unused_mix;
            assign unused_mix   = ^mix;
            assign level_next_d = mix[MIX_W-1 -: PWM_W];
        end else begin : g_pad
            assign level_next_d = {mix, {(PWM_W-MIX_W){1'b0}}};
        end
    endgenerate

    // Capture pipeline keyed to the free-running counter; level only moves at the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            sum_q         <= '0;
            level_next_q  <= '0;
            level_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_q + PWM_W'(1);
            frame_start_q <= (cnt_q == CNT_MAX);
            if (cnt_q == SUM_AT) begin
                sum_q <= sum_d;
            end
            if (cnt_q == LEVEL_AT) begin
                level_next_q <= level_next_d;
            end
            if (cnt_q == CNT_MAX) begin
                level_q <= level_next_q;
            end
        end
    end

    sid_audio_mod #(
        .PWM_W (PWM_W)
    ) u_mod (
        .clk       (clk),
        .rst       (rst),
        .cnt       (cnt_q),
        .level     (level_q),
        .audio_out (audio_out)
    );

    assign level       = level_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sid_audio_out.sv
// Self-checking bench for sid_audio_out: randomized voices/mute/volume against a
// frame-level arithmetic model of the mixer and the modulator's ones density.
module tb_sid_audio_out;

    localparam int NV    = 3;
    localparam int VW    = 8;
    localparam int PW    = 8;
    localparam int FRAME = 1 << PW;
    localparam int SHIFT = VW + $clog2(NV) + 4 - PW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NV*VW-1:0]  voices;
    logic [NV-1:0]     voiceMute;
    logic [3:0]        volume;
    logic [PW-1:0]     level;
    logic              frameStart;
    logic              audioOut;

    int checks = 0;
    int errors = 0;

    int pos;
    int smpSum, nextLvl, expLevel, lvlDone;
    int winOnes, winCount, winLevel;
    bit winFull, winValid, consec, winConsec, prevA;

    always #5 clk = ~clk;

    sid_audio_out #(
        .NUM_VOICES (NV),
        .VOICE_W    (VW),
        .PWM_W      (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .voices      (voices),
        .voice_mute  (voiceMute),
        .volume      (volume),
        .level       (level),
        .frame_start (frameStart),
        .audio_out   (audioOut)
    );

    function automatic int modelSum();
        int s;
        s = 0;
        for (int i = 0; i < NV; i++) begin
            if (!voiceMute[i]) s += int'(voices[i*VW +: VW]);
        end
        return s;
    endfunction

    function automatic int modelLevel(input int s, input int v);
        return (s * v) >> SHIFT;
    endfunction

    task automatic setVoices(input int a, input int b, input int c);
        voices = {VW'(c), VW'(b), VW'(a)};
    endtask

    // One clock: frame model advances, and the ones density of each 256-cycle
    // window (positions 1..255 plus the following 0) is recorded.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (rst) begin
            pos = 0; smpSum = 0; nextLvl = 0; expLevel = 0;
            winFull = 0; winOnes = 0; consec = 0; prevA = 0;
        end else begin
            if (pos == FRAME-3) smpSum = modelSum();
            if (pos == FRAME-2) nextLvl = modelLevel(smpSum, int'(volume));
            if (pos == FRAME-1) begin
                lvlDone  = expLevel;
                expLevel = nextLvl;
            end
            pos = (pos + 1) % FRAME;
            if (pos == 1) begin
                winValid = winFull; winCount = winOnes; winLevel = lvlDone;
                winConsec = consec; winFull = 1; winOnes = 0; consec = 0; prevA = 0;
            end
            if (audioOut === 1'b1) begin
                winOnes++;
                if (prevA) consec = 1;
                prevA = 1;
            end else begin
                prevA = 0;
            end
        end
    endtask

    task automatic runTo(input int target);
        int n;
        n = 0;
        while (pos != target && n <= FRAME) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int early;
        voices = '0; voiceMute = '0; volume = '0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (level !== 8'd0) begin errors++; $display("[TB] FAIL reset_level got %0d want 0", level); end
        checks++; if (audioOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_audio got %b want 0", audioOut); end
        checks++; if (frameStart !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_start got %b want 0", frameStart); end
        early = 0;
        for (int i = 1; i < FRAME; i++) begin
            tick();
            if (frameStart === 1'b1) early++;
        end
        checks++; if (early != 0) begin errors++; $display("[TB] FAIL reset_early_frame_start got %0d pulses want 0", early); end
        tick();
        checks++; if (frameStart !== 1'b1) begin errors++; $display("[TB] FAIL reset_first_frame_start got %b want 1", frameStart); end
        checks++; if (level !== PW'(expLevel)) begin errors++; $display("[TB] FAIL reset_first_level got %0d want %0d", level, expLevel); end
    endtask

    task automatic test_full_scale();
        runTo(1);
        setVoices(255, 255, 255); voiceMute = '0; volume = 4'd15;
        runTo(0);
        checks++; if (level !== 8'd179) begin errors++; $display("[TB] FAIL full_level got %0d want 179", level); end
        for (int i = 1; i <= FRAME; i++) begin
            tick();
            checks++; if (frameStart !== (pos == 0)) begin errors++; $display("[TB] FAIL full_frame_start pos %0d got %b", pos, frameStart); end
            checks++; if (level !== 8'd179) begin errors++; $display("[TB] FAIL full_level_hold pos %0d got %0d want 179", pos, level); end
`ifndef SID_AUDIO_DELTA_SIGMA_EN
            if (pos != 0) begin
                checks++;
                if (audioOut !== ((pos - 1) < 179)) begin
                    errors++; $display("[TB] FAIL full_pwm_bit pos %0d got %b want %b", pos, audioOut, ((pos - 1) < 179));
                end
            end
`endif
        end
        tick();
        checks++; if (!winValid || winCount != 179) begin errors++; $display("[TB] FAIL full_ones got %0d want 179", winCount); end
    endtask

    task automatic test_volume_zero();
        runTo(1);
        setVoices($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        voiceMute = '0; volume = 4'd0;
        runTo(0);
        checks++; if (level !== 8'd0) begin errors++; $display("[TB] FAIL volzero_level got %0d want 0", level); end
        runTo(1); runTo(0); runTo(1);
        checks++; if (!winValid || winCount != 0) begin errors++; $display("[TB] FAIL volzero_ones got %0d want 0", winCount); end
    endtask

    task automatic test_mute();
        runTo(1);
        setVoices(128, 64, 32); voiceMute = 3'b011; volume = 4'd15;
        runTo(0);
        checks++; if (level !== 8'd7) begin errors++; $display("[TB] FAIL mute_level got %0d want 7", level); end
        runTo(1); runTo(0); runTo(1);
        checks++; if (!winValid || winCount != 7) begin errors++; $display("[TB] FAIL mute_ones got %0d want 7", winCount); end
    endtask

    task automatic test_volume_change();
        int a, b, c, oldLvl, newLvl;
        a = $urandom_range(100, 255); b = $urandom_range(100, 255); c = $urandom_range(100, 255);
        oldLvl = ((a + b + c) * 15) >> SHIFT;
        newLvl = ((a + b + c) * 8) >> SHIFT;
        runTo(1);
        setVoices(a, b, c); voiceMute = '0; volume = 4'd15;
        runTo(0);
        checks++; if (level !== PW'(oldLvl)) begin errors++; $display("[TB] FAIL volchg_old got %0d want %0d", level, oldLvl); end
        runTo(200);
        volume = 4'd8;
        for (int i = 0; i < FRAME - 200; i++) begin
            tick();
            if (pos != 0) begin
                checks++; if (level !== PW'(oldLvl)) begin errors++; $display("[TB] FAIL volchg_hold pos %0d got %0d want %0d", pos, level, oldLvl); end
            end else begin
                checks++; if (level !== PW'(newLvl)) begin errors++; $display("[TB] FAIL volchg_new got %0d want %0d", level, newLvl); end
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            runTo($urandom_range(0, FRAME - 1));
            setVoices($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            voiceMute = NV'($urandom_range(0, 7));
            volume    = 4'($urandom_range(0, 15));
            runTo(0);
            checks++; if (level !== PW'(expLevel)) begin errors++; $display("[TB] FAIL rand_level it %0d got %0d want %0d", it, level, expLevel); end
            runTo(1);
            checks++; if (!winValid || winCount != winLevel) begin errors++; $display("[TB] FAIL rand_ones it %0d got %0d want %0d", it, winCount, winLevel); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        runTo(1);
        setVoices(255, 255, 255); voiceMute = '0; volume = 4'd15;
        runTo(0);
        runTo(100);
        checks++; if (level !== 8'd179) begin errors++; $display("[TB] FAIL midrst_pre_level got %0d want 179", level); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (audioOut !== 1'b0) begin errors++; $display("[TB] FAIL midrst_audio got %b want 0", audioOut); end
        checks++; if (level !== 8'd0) begin errors++; $display("[TB] FAIL midrst_level got %0d want 0", level); end
        checks++; if (frameStart !== 1'b0) begin errors++; $display("[TB] FAIL midrst_frame_start got %b want 0", frameStart); end
        n = 0;
        do begin
            tick();
            n++;
        end while (frameStart !== 1'b1 && n < 300);
        checks++; if (n != FRAME) begin errors++; $display("[TB] FAIL midrst_first_frame got %0d cycles want %0d", n, FRAME); end
        checks++; if (level !== 8'd179) begin errors++; $display("[TB] FAIL midrst_first_level got %0d want 179", level); end
    endtask

    task automatic test_density64();
        runTo(1);
        setVoices(255, 255, 2); voiceMute = '0; volume = 4'd8;
        runTo(0);
        checks++; if (level !== 8'd64) begin errors++; $display("[TB] FAIL d64_level got %0d want 64", level); end
        runTo(1); runTo(0); runTo(1);
        checks++; if (!winValid || winCount != 64) begin errors++; $display("[TB] FAIL d64_ones got %0d want 64", winCount); end
`ifdef SID_AUDIO_DELTA_SIGMA_EN
        checks++; if (winConsec !== 1'b0) begin errors++; $display("[TB] FAIL d64_consecutive got %b want 0", winConsec); end
`endif
    endtask

    initial begin
        rst = 1'b1; voices = '0; voiceMute = '0; volume = '0;
        pos = 0; smpSum = 0; nextLvl = 0; expLevel = 0; lvlDone = 0;
        winOnes = 0; winCount = 0; winLevel = 0;
        winFull = 0; winValid = 0; consec = 0; winConsec = 0; prevA = 0;
        test_reset();
        test_full_scale();
        test_volume_zero();
        test_mute();
        test_volume_change();
        test_random();
        test_reset_mid();
        test_density64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
